// File: rtl/counter_sched_pkg.sv
// Shared constants and FSM state type for the counter scheduler slice.
package counter_sched_pkg;

    localparam int CNT_W       = 10;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_next
);

    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_pick;
    logic [PTR_W-1:0]   w_idx;

    // Rotate so ptr lands on bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        w_rot    = '0;
        gnt_next = '0;
        w_idx    = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            w_idx    = PTR_W'((j + 32'(ptr)) % NUM_REQ);
            w_rot[j] = req[w_idx];
        end
        w_pick = w_rot & (~w_rot + NUM_REQ'(1));
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            w_idx           = PTR_W'((j + 32'(ptr)) % NUM_REQ);
            gnt_next[w_idx] = w_pick[j];
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one external up-counter among NUM_REQ requesters, round-robin,
// clearing and enabling it until each owner's latched terminal count.
module counter_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = counter_sched_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     cnt_clear,
    output logic                     cnt_en,
    input  logic [CNT_W-1:0]         cnt_value
);
    import counter_sched_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [CNT_W-1:0]   r_len;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_busy;
    logic               r_clear;

    logic [NUM_REQ-1:0] w_gnt_next;
    logic [CNT_W-1:0]   w_len_next;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               w_owner_req;
    logic               w_at_term;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req      (req),
        .ptr      (r_ptr),
        .gnt_next (w_gnt_next)
    );

    always_comb begin
        w_len_next = '0;
        w_ptr_next = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_next[i]) w_len_next = req_len[i*CNT_W +: CNT_W];
            if (r_grant[i])    w_ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
        end
    end

    assign w_owner_req = |(req & r_grant);
    assign w_at_term   = (cnt_value == r_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_len   <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant <= w_gnt_next;
                        r_len   <= w_len_next;
                        r_busy  <= 1'b1;
                        r_clear <= 1'b1;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_clear <= 1'b0;
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_IDLE;
                    end else if (w_at_term) begin
                        r_done  <= r_grant;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_ptr_next;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Enable is gated live so an owner dropping req stops the count that cycle.
    assign cnt_en    = (r_state == ST_RUN) && !w_at_term && w_owner_req;
    assign grant     = r_grant;
    assign done      = r_done;
    assign busy      = r_busy;
    assign cnt_clear = r_clear;

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler with a behavioural 10-bit counter.
module tb_counter_scheduler;
    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_len = '0;
    logic [N-1:0]   grant, done;
    logic           busy, cnt_clear, cnt_en;
    logic [W-1:0]   cnt_value = '0;

    int n_cmp = 0;
    int n_err = 0;
    int model_ptr = 0;

    counter_scheduler #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk(clk), .reset(rst_n), .req(req), .req_len(req_len), .grant(grant), .done(done),
        .busy(busy), .cnt_clear(cnt_clear), .cnt_en(cnt_en), .cnt_value(cnt_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_clear)   cnt_value <= '0;
        else if (cnt_en) cnt_value <= cnt_value + 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int rr_pick(logic [N-1:0] m, int p);
        for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_len(int i, int L);
        req_len[i*W +: W] = W'(L);
    endtask

    // Observes one grant interval (waiting for it if necessary); returns at the first idle sample after it.
    task automatic measure(output logic [N-1:0] g, output int idle, output int cyc, output int ndone,
                           output logic [N-1:0] dval, output int dcyc, output logic [W-1:0] dcnt,
                           output int nen, output int nclr, output logic [W-1:0] c2,
                           output bit stable, output bit tout);
        g = '0; idle = 0; cyc = 0; ndone = 0; dval = '0; dcyc = 0; dcnt = '0;
        nen = 0; nclr = 0; c2 = '1; stable = 1'b1; tout = 1'b0;
        while (grant == '0 && idle < 3000) begin idle++; @(negedge clk); end
        if (grant == '0) begin tout = 1'b1; return; end
        g = grant;
        while (grant != '0 && cyc < 3000) begin
            cyc++;
            if (grant !== g) stable = 1'b0;
            if (done != '0) begin ndone++; dval = done; dcyc = cyc; dcnt = cnt_value; end
            if (cnt_en) nen++;
            if (cnt_clear) nclr++;
            if (cyc == 2) c2 = cnt_value;
            @(negedge clk);
        end
        if (grant != '0) tout = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = '0; req_len = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL rst_grant: got %b expected 0000", grant); end
        n_cmp++; if (done !== '0) begin n_err++; $display("FAIL rst_done: got %b expected 0000", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (cnt_clear !== 1'b0) begin n_err++; $display("FAIL rst_clear: got %b expected 0", cnt_clear); end
        n_cmp++; if (cnt_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b expected 0", cnt_en); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
        model_ptr = 0;
    endtask

    task automatic test_single;
        logic [N-1:0] g, dval; logic [W-1:0] dcnt, c2; int idle, cyc, ndone, dcyc, nen, nclr; bit stable, tout;
        set_len(1, 5); req = 4'b0010;
        measure(g, idle, cyc, ndone, dval, dcyc, dcnt, nen, nclr, c2, stable, tout);
        req = '0;
        n_cmp++; if (tout !== 1'b0) begin n_err++; $display("FAIL t1_timeout: got %0d expected 0", tout); end
        n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL t1_grant: got %b expected 0010", g); end
        n_cmp++; if (idle !== 1) begin n_err++; $display("FAIL t1_latency: got %0d expected 1", idle); end
        n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL t1_grant_len: got %0d expected 8", cyc); end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL t1_stable: got %0d expected 1", stable); end
        n_cmp++; if (ndone !== 1 || dval !== 4'b0010) begin n_err++; $display("FAIL t1_done: got %0d x %b expected 1 x 0010", ndone, dval); end
        n_cmp++; if (dcyc !== 8 || dcnt !== 10'd5) begin n_err++; $display("FAIL t1_done_at: got cyc %0d cnt %0d expected cyc 8 cnt 5", dcyc, dcnt); end
        n_cmp++; if (nen !== 5) begin n_err++; $display("FAIL t1_en_cycles: got %0d expected 5", nen); end
        n_cmp++; if (nclr !== 1) begin n_err++; $display("FAIL t1_clear_cycles: got %0d expected 1", nclr); end
        n_cmp++; if (c2 !== 10'd0) begin n_err++; $display("FAIL t1_first_run_cnt: got %0d expected 0", c2); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_busy_after: got %b expected 0", busy); end
        model_ptr = 2;
    endtask

    task automatic test_round_robin;
        logic [N-1:0] g, dval; logic [W-1:0] dcnt, c2; int idle, cyc, ndone, dcyc, nen, nclr; bit stable, tout;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 2);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            measure(g, idle, cyc, ndone, dval, dcyc, dcnt, nen, nclr, c2, stable, tout);
            if (k == 4) req = '0;
            n_cmp++; if (g !== onehot(exp_order[k]) || tout) begin n_err++; $display("FAIL t2_order[%0d]: got %b expected %b", k, g, onehot(exp_order[k])); end
            n_cmp++; if (cyc !== 5 || idle !== 1) begin n_err++; $display("FAIL t2_timing[%0d]: got len %0d idle %0d expected len 5 idle 1", k, cyc, idle); end
            n_cmp++; if (ndone !== 1 || dval !== g) begin n_err++; $display("FAIL t2_done[%0d]: got %0d x %b expected 1 x %b", k, ndone, dval, g); end
        end
        model_ptr = 1;
    endtask

    task automatic test_zero_len;
        logic [N-1:0] g, dval; logic [W-1:0] dcnt, c2; int idle, cyc, ndone, dcyc, nen, nclr; bit stable, tout;
        set_len(2, 0); req = 4'b0100;
        measure(g, idle, cyc, ndone, dval, dcyc, dcnt, nen, nclr, c2, stable, tout);
        req = '0;
        n_cmp++; if (g !== 4'b0100 || tout) begin n_err++; $display("FAIL t3_grant: got %b expected 0100", g); end
        n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL t3_grant_len: got %0d expected 3", cyc); end
        n_cmp++; if (nen !== 0) begin n_err++; $display("FAIL t3_en_cycles: got %0d expected 0", nen); end
        n_cmp++; if (ndone !== 1 || dval !== 4'b0100 || dcnt !== 10'd0) begin n_err++; $display("FAIL t3_done: got %0d x %b cnt %0d expected 1 x 0100 cnt 0", ndone, dval, dcnt); end
        model_ptr = 3;
    endtask

    task automatic test_max_len;
        logic [N-1:0] g, dval; logic [W-1:0] dcnt, c2; int idle, cyc, ndone, dcyc, nen, nclr; bit stable, tout;
        set_len(0, 1023); req = 4'b0001;
        measure(g, idle, cyc, ndone, dval, dcyc, dcnt, nen, nclr, c2, stable, tout);
        req = '0;
        n_cmp++; if (g !== 4'b0001 || tout) begin n_err++; $display("FAIL t4_grant: got %b expected 0001", g); end
        n_cmp++; if (cyc !== 1026 || dcyc !== 1026) begin n_err++; $display("FAIL t4_grant_len: got %0d done at %0d expected 1026", cyc, dcyc); end
        n_cmp++; if (dcnt !== 10'd1023 || nen !== 1023) begin n_err++; $display("FAIL t4_count: got cnt %0d en %0d expected 1023 1023", dcnt, nen); end
        n_cmp++; if (ndone !== 1) begin n_err++; $display("FAIL t4_done: got %0d expected 1", ndone); end
        model_ptr = 1;
    endtask

    task automatic test_abort;
        logic [N-1:0] g, dval; logic [W-1:0] dcnt, c2; int idle, cyc, ndone, dcyc, nen, nclr; bit stable, tout;
        int w, n; bit saw_done;
        set_len(3, 20); set_len(0, 3); req = 4'b1001;
        w = rr_pick(req, model_ptr);
        n = 0; saw_done = 1'b0;
        @(negedge clk);
        while (!(cnt_value == 10'd7 && cnt_en) && n < 60) begin
            if (done != '0) saw_done = 1'b1;
            n++; @(negedge clk);
        end
        n_cmp++; if (n >= 60) begin n_err++; $display("FAIL t5_reach7: got timeout expected count 7"); end
        n_cmp++; if (grant !== onehot(w)) begin n_err++; $display("FAIL t5_owner: got %b expected %b", grant, onehot(w)); end
        req = 4'b0001;
        #1;
        n_cmp++; if (cnt_en !== 1'b0) begin n_err++; $display("FAIL t5_en_gate: got %b expected 0", cnt_en); end
        @(negedge clk);
        n_cmp++; if (grant !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL t5_idle: got grant %b busy %b expected 0000 0", grant, busy); end
        n_cmp++; if (saw_done || done !== '0) begin n_err++; $display("FAIL t5_no_done: got %b expected 0000", done); end
        @(negedge clk);
        measure(g, idle, cyc, ndone, dval, dcyc, dcnt, nen, nclr, c2, stable, tout);
        req = '0;
        n_cmp++; if (g !== 4'b0001 || idle !== 0) begin n_err++; $display("FAIL t5_next: got %b idle %0d expected 0001 idle 0", g, idle); end
        n_cmp++; if (cyc !== 6 || ndone !== 1 || dcnt !== 10'd3) begin n_err++; $display("FAIL t5_next_len: got %0d done %0d cnt %0d expected 6 1 3", cyc, ndone, dcnt); end
        model_ptr = 1;
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] g, dval; logic [W-1:0] dcnt, c2; int idle, cyc, ndone, dcyc, nen, nclr; bit stable, tout;
        int n;
        set_len(1, 10); req = 4'b0010; n = 0;
        @(negedge clk);
        while (!(cnt_value == 10'd4 && cnt_en) && n < 40) begin n++; @(negedge clk); end
        n_cmp++; if (n >= 40 || grant !== 4'b0010) begin n_err++; $display("FAIL t6_reach4: got grant %b expected 0010", grant); end
        rst_n = 1'b0; req = 4'b0101; set_len(0, 2); set_len(2, 1);
        #1;
        n_cmp++; if ({grant, done, busy, cnt_clear, cnt_en} !== '0) begin n_err++; $display("FAIL t6_async_rst: got %b %b %b%b%b expected all 0", grant, done, busy, cnt_clear, cnt_en); end
        @(negedge clk);
        rst_n = 1'b1;
        measure(g, idle, cyc, ndone, dval, dcyc, dcnt, nen, nclr, c2, stable, tout);
        req = 4'b0100;
        n_cmp++; if (g !== 4'b0001 || idle !== 1 || cyc !== 5) begin n_err++; $display("FAIL t6_first: got %b idle %0d len %0d expected 0001 1 5", g, idle, cyc); end
        measure(g, idle, cyc, ndone, dval, dcyc, dcnt, nen, nclr, c2, stable, tout);
        req = '0;
        n_cmp++; if (g !== 4'b0100 || cyc !== 4 || ndone !== 1) begin n_err++; $display("FAIL t6_second: got %b len %0d done %0d expected 0100 4 1", g, cyc, ndone); end
    endtask

    task automatic test_random;
        logic [N-1:0] g, dval; logic [W-1:0] dcnt, c2; int idle, cyc, ndone, dcyc, nen, nclr; bit stable, tout;
        logic [N-1:0] mask; int lens [N]; int w;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        model_ptr = 0;
        for (int it = 0; it < 30; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin lens[i] = $urandom_range(0, 12); set_len(i, lens[i]); end
            w = rr_pick(mask, model_ptr);
            req = mask;
            fork
                measure(g, idle, cyc, ndone, dval, dcyc, dcnt, nen, nclr, c2, stable, tout);
                begin
                    repeat (3) @(negedge clk);
                    #1;
                    req = N'($urandom()) | onehot(w);
                    req_len = (N*W)'({$urandom(), $urandom()});
                end
            join
            n_cmp++; if (g !== onehot(w) || tout) begin n_err++; $display("FAIL rnd_grant[%0d]: got %b expected %b", it, g, onehot(w)); end
            n_cmp++; if (cyc !== lens[w] + 3 || !stable) begin n_err++; $display("FAIL rnd_len[%0d]: got %0d expected %0d", it, cyc, lens[w] + 3); end
            n_cmp++; if (ndone !== 1 || dval !== onehot(w) || dcnt !== W'(lens[w])) begin n_err++; $display("FAIL rnd_done[%0d]: got %0d x %b cnt %0d expected 1 x %b cnt %0d", it, ndone, dval, dcnt, onehot(w), lens[w]); end
            n_cmp++; if (nen !== lens[w] || busy !== 1'b0) begin n_err++; $display("FAIL rnd_en[%0d]: got %0d busy %b expected %0d busy 0", it, nen, busy, lens[w]); end
            model_ptr = (w + 1) % N;
        end
        req = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_zero_len;
        test_max_len;
        test_abort;
        test_reset_mid;
        test_random;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
